spi_slave_reg: RTL

//  SPI receiver (slave) matching spi_master_reg frames. It oversamples sclk/n_cs/mosi in sys_clk,

---
 rtl/ast_bos_pkg.sv | 19 +
 rtl/sync_edge.sv | 26 ++
 rtl/spi_slave_reg.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ast_bos_pkg.sv
// ast_bos_pkg: shared definitions for the DAC bus SPI path.
// Slave FSM state encoding and DAC frame field positions.
package ast_bos_pkg;

    typedef enum logic [1:0] {
        WAIT_HI = 2'd0,
        IDLE    = 2'd1,
        RECV    = 2'd2,
        OVER    = 2'd3
    } spi_state_t;

    localparam logic [3:0] CMD_WR_UPD = 4'b0011;

    localparam int CMD_MSB  = 23;
    localparam int CMD_LSB  = 20;
    localparam int DATA_MSB = 19;
    localparam int DATA_LSB = 4;

endpackage

// File: rtl/sync_edge.sv
// sync_edge: 2-FF synchronizer with rise/fall pulses on the synced level.
// The third flop only remembers the previous synced value for edge detection.
module sync_edge #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [2:0] q;

    // Shift the async input through two sync stages plus one history stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= {3{RST_VAL}};
        else        q <= {q[1:0], din};
    end

    assign dout = q[1];
    assign rise = q[1] & ~q[2];
    assign fall = ~q[1] & q[2];

endmodule

// File: rtl/spi_slave_reg.sv
// spi_slave_reg: oversampled SPI slave, MSB-first, one word per good frame.
// Counts good and bad frames with saturating counters.
module spi_slave_reg
    import ast_bos_pkg::*;
#(
    parameter int CPOL  = 1,
    parameter int CPHA  = 1,
    parameter int WIDTH = 24,
    parameter int CNT_W = 16
) (
    input  logic             sys_clk,
    input  logic             n_rst,
    input  logic             sclk,
    input  logic             mosi,
    input  logic             n_cs,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ena,
    output logic             frame_err,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam bit RISE_SAMPLE = (CPOL == CPHA);

    logic sclk_s, sclk_rise, sclk_fall;
    logic ncs_s, ncs_rise, ncs_fall;
    logic [1:0] mosi_q;
    logic mosi_s, sample;

    spi_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [1:0] settle;
    logic close_good, close_bad, to_over;

    sync_edge #(.RST_VAL(CPOL != 0)) u_sclk (
        .clk(sys_clk), .rst_n(n_rst), .din(sclk),
        .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    sync_edge #(.RST_VAL(1'b1)) u_ncs (
        .clk(sys_clk), .rst_n(n_rst), .din(n_cs),
        .dout(ncs_s), .rise(ncs_rise), .fall(ncs_fall)
    );

    // Delay mosi by the same two stages as sclk and n_cs.
    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) mosi_q <= 2'b00;
        else        mosi_q <= {mosi_q[0], mosi};
    end

    assign mosi_s = mosi_q[1];
    assign sample = (sclk_rise | sclk_fall) & (sclk_s == RISE_SAMPLE);
    assign busy   = (state == RECV) || (state == OVER);

    // Next state, shift/count update and frame-close decision.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        shreg_n    = shreg;
        close_good = 1'b0;
        close_bad  = 1'b0;
        to_over    = 1'b0;
        unique case (state)
            WAIT_HI: begin
                if (settle[1] && ncs_s) state_n = IDLE;
            end
            IDLE: begin
                if (ncs_fall) begin
                    cnt_n   = '0;
                    shreg_n = '0;
                    state_n = RECV;
                end
            end
            RECV: begin
                if (sample) begin
                    if (cnt == CW'(WIDTH)) begin
                        to_over = 1'b1;
                        state_n = OVER;
                    end else begin
                        cnt_n   = cnt + 1'b1;
                        shreg_n = {shreg[WIDTH-2:0], mosi_s};
                    end
                end
                if (ncs_rise) begin
                    state_n = IDLE;
                    if (!to_over && cnt_n == CW'(WIDTH)) close_good = 1'b1;
                    else                                 close_bad  = 1'b1;
                end
            end
            OVER: begin
                if (ncs_rise) begin
                    state_n   = IDLE;
                    close_bad = 1'b1;
                end
            end
            default: state_n = WAIT_HI;
        endcase
    end

    // FSM state and datapath; settle keeps WAIT_HI from trusting reset-valued sync flops.
    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) begin
            state  <= WAIT_HI;
            cnt    <= '0;
            shreg  <= '0;
            settle <= 2'b00;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            shreg  <= shreg_n;
            settle <= {settle[0], 1'b1};
        end
    end

    // Registered frame-close strobes, output word and saturating counters.
    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) begin
            out_data  <= '0;
            out_ena   <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            out_ena   <= close_good;
            frame_err <= close_bad;
            if (close_good) begin
                out_data <= shreg_n;
                if (frame_cnt != '1) frame_cnt <= frame_cnt + 1'b1;
            end
            if (close_bad && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule
